// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and state encoding for the register-file sequencer/arbiter.
package regfile_ctrl_pkg;

  localparam int RFC_NREG         = 15;
  localparam int RFC_ADDR_W       = 4;
  localparam int RFC_DATA_W       = 64;
  localparam int RFC_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    RFC_INIT  = 2'd0,
    RFC_RUN   = 2'd1,
    RFC_FORCE = 2'd2
  } rfc_state_e;

endpackage

// File: rtl/regfile_ctrl_portsel.sv
// Combinational port selection for a debug access: which write port is idle and
// collision-free, and whether read port B is idle this cycle.
module regfile_ctrl_portsel #(
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] i_dst_m,
  input  logic [ADDR_W-1:0] i_dst_e,
  input  logic [ADDR_W-1:0] i_src_b,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_use_e,
  output logic              o_use_m,
  output logic              o_b_free
);

  localparam logic [ADDR_W-1:0] ANONE = '1;

  logic w_e_idle;
  logic w_m_idle;
  logic w_hit_m;
  logic w_hit_e;

  assign w_e_idle = (i_dst_e == ANONE);
  assign w_m_idle = (i_dst_m == ANONE);
  assign w_hit_m  = !w_m_idle && (i_addr == i_dst_m);
  assign w_hit_e  = !w_e_idle && (i_addr == i_dst_e);

  // Refusing a write that collides with the other port keeps per-address write order defined.
  assign o_use_e  = w_e_idle && !w_hit_m;
  assign o_use_m  = !o_use_e && w_m_idle && !w_hit_e;
  assign o_b_free = (i_src_b == ANONE);

endmodule

// File: rtl/regfile_ctrl.sv
// Sequencer and port arbiter in front of the Y86-64 register file: clears every
// register after reset, then passes the pipeline through and slots in debug accesses.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int NREG         = RFC_NREG,
  parameter int ADDR_W       = RFC_ADDR_W,
  parameter int DATA_W       = RFC_DATA_W,
  parameter int STARVE_LIMIT = RFC_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] W_dstM_i,
  input  logic [ADDR_W-1:0] W_dstE_i,
  input  logic [DATA_W-1:0] W_valM_i,
  input  logic [DATA_W-1:0] W_valE_i,
  input  logic [ADDR_W-1:0] d_srcA_i,
  input  logic [ADDR_W-1:0] d_srcB_i,
  output logic [ADDR_W-1:0] rf_dstM_o,
  output logic [ADDR_W-1:0] rf_dstE_o,
  output logic [DATA_W-1:0] rf_valM_o,
  output logic [DATA_W-1:0] rf_valE_o,
  output logic [ADDR_W-1:0] rf_srcA_o,
  output logic [ADDR_W-1:0] rf_srcB_o,
  input  logic [DATA_W-1:0] rf_rvalB_i,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              stall_o,
  output logic              busy_o
);

  localparam int                WAIT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] ANONE     = '1;
  localparam logic [ADDR_W-1:0] INIT_LAST = ADDR_W'(NREG - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_LIMIT - 1);

  rfc_state_e        r_state;
  rfc_state_e        w_state_next;
  logic [ADDR_W-1:0] r_init_cnt;
  logic [WAIT_W-1:0] r_wait;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  logic w_use_e;
  logic w_use_m;
  logic w_b_free;
  logic w_run_gnt;
  logic w_gnt;
  logic w_rd_gnt;
  logic w_starve;

  regfile_ctrl_portsel #(
    .ADDR_W(ADDR_W)
  ) u_portsel (
    .i_dst_m  (W_dstM_i),
    .i_dst_e  (W_dstE_i),
    .i_src_b  (d_srcB_i),
    .i_addr   (dbg_addr_i),
    .o_use_e  (w_use_e),
    .o_use_m  (w_use_m),
    .o_b_free (w_b_free)
  );

  assign w_run_gnt = dbg_req_i && (dbg_we_i ? (w_use_e || w_use_m) : w_b_free);
  assign w_gnt     = ((r_state == RFC_RUN) && w_run_gnt) || ((r_state == RFC_FORCE) && dbg_req_i);
  assign w_rd_gnt  = w_gnt && !dbg_we_i;
  assign w_starve  = (r_state == RFC_RUN) && dbg_req_i && !w_run_gnt && (r_wait == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RFC_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RFC_INIT:  if (r_init_cnt == INIT_LAST) w_state_next = RFC_RUN;
      RFC_RUN:   if (w_starve) w_state_next = RFC_FORCE;
      RFC_FORCE: w_state_next = RFC_RUN;
      default:   w_state_next = RFC_INIT;
    endcase
  end

  always_comb begin
    rf_dstM_o = W_dstM_i;
    rf_dstE_o = W_dstE_i;
    rf_valM_o = W_valM_i;
    rf_valE_o = W_valE_i;
    rf_srcA_o = d_srcA_i;
    rf_srcB_o = d_srcB_i;
    stall_o   = 1'b0;
    busy_o    = 1'b0;
    case (r_state)
      RFC_INIT: begin
        rf_dstE_o = r_init_cnt;
        rf_valE_o = '0;
        rf_dstM_o = ANONE;
        rf_srcA_o = ANONE;
        rf_srcB_o = ANONE;
        stall_o   = 1'b1;
        busy_o    = 1'b1;
      end
      RFC_FORCE: begin
        // Pipeline is held; its W-stage write replays once RUN resumes.
        stall_o   = 1'b1;
        rf_dstM_o = ANONE;
        rf_dstE_o = ANONE;
        rf_srcB_o = ANONE;
        if (w_gnt) begin
          if (dbg_we_i) begin
            rf_dstE_o = dbg_addr_i;
            rf_valE_o = dbg_wdata_i;
          end else begin
            rf_srcB_o = dbg_addr_i;
          end
        end
      end
      default: begin
        if (w_gnt) begin
          if (!dbg_we_i) begin
            rf_srcB_o = dbg_addr_i;
          end else if (w_use_e) begin
            rf_dstE_o = dbg_addr_i;
            rf_valE_o = dbg_wdata_i;
          end else begin
            rf_dstM_o = dbg_addr_i;
            rf_valM_o = dbg_wdata_i;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init_cnt <= '0;
      r_wait     <= '0;
    end else begin
      r_init_cnt <= ((r_state == RFC_INIT) && (r_init_cnt != INIT_LAST)) ? r_init_cnt + 1'b1 : '0;
      if ((r_state == RFC_RUN) && dbg_req_i && !w_run_gnt && !w_starve) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
    end
  end

  // Address F is "no register", so its read returns zero whatever the file drives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_rdata <= (dbg_addr_i == ANONE) ? '0 : rf_rvalB_i;
      end
    end
  end

  assign dbg_gnt_o    = w_gnt;
  assign dbg_rvalid_o = r_rvalid;
  assign dbg_rdata_o  = r_rdata;

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Sequencer and port arbiter placed in front of the 15-entry Y86-64 register file (2 write ports M/E, 2 read ports A/B).
- After reset, clears every register to zero by driving the E write port once per cycle while stalling the pipeline.
- In RUN, passes W-stage writes and D-stage reads straight through, and slots a debug/host single-register read/write access into idle port cycles.
- If no idle cycle occurs within a bounded wait, it forces a one-cycle pipeline stall to free a port.

Parameters:
- NREG, 15, number of architectural registers; address NREG (4'hF) means "no register".
- ADDR_W, 4, register address width (matches REG_ADDR_BUS).
- DATA_W, 64, data width (matches DATA_BUS).
- STARVE_LIMIT, 4, cycles a debug request may wait before a forced stall.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- W_dstM_i / W_dstE_i  in  ADDR_W each  pipeline write addresses.
- W_valM_i / W_valE_i  in  DATA_W each  pipeline write data.
- d_srcA_i / d_srcB_i  in  ADDR_W each  pipeline read addresses.
- rf_dstM_o / rf_dstE_o  out  ADDR_W each  to register file.
- rf_valM_o / rf_valE_o  out  DATA_W each  to register file.
- rf_srcA_o / rf_srcB_o  out  ADDR_W each  to register file.
- rf_rvalB_i  in  DATA_W  register file read port B data.
- dbg_req_i  in  1  debug request; held with fields stable until grant.
- dbg_we_i  in  1  1 = write, 0 = read.
- dbg_addr_i  in  ADDR_W  debug register address.
- dbg_wdata_i  in  DATA_W  debug write data.
- dbg_gnt_o  out  1  one-cycle grant; the access occurs in that cycle.
- dbg_rvalid_o  out  1  one-cycle pulse, read data valid.
- dbg_rdata_o  out  DATA_W  registered read data.
- stall_o  out  1  pipeline must hold F/D/E/M/W this cycle.
- busy_o  out  1  high while in INIT.

Behaviour:
- Reset (rst=1, asynchronous):
  - State goes to INIT, init counter to 0, wait counter to 0.
  - stall_o=1, busy_o=1, dbg_gnt_o=0, dbg_rvalid_o=0, dbg_rdata_o=0.
  - Any pending debug request is dropped without a grant. Reset mid-INIT or mid-access restarts INIT.
- States: INIT, RUN, FORCE.
- INIT:
  - Drive rf_dstE_o=counter, rf_valE_o=0, rf_dstM_o=4'hF, rf_srcA_o=rf_srcB_o=4'hF.
  - Counter increments 0..NREG-1. After writing NREG-1, move to RUN. INIT lasts exactly NREG cycles after reset release.
  - stall_o=busy_o=1 throughout. dbg_gnt_o=0.
- RUN, default: rf_* outputs equal the W_*/d_* inputs (combinational pass-through). stall_o=0.
- RUN, debug write pending:
  - Grant in the same cycle if W_dstE_i==4'hF (use E port), else if W_dstM_i==4'hF (use M port).
  - Never grant when dbg_addr_i equals the other port's active destination. Wait instead; this keeps write order defined.
  - The debug value always wins over the pipeline value for that address in that cycle.
- RUN, debug read pending:
  - Grant when d_srcB_i==4'hF: drive rf_srcB_o=dbg_addr_i.
  - Register rf_rvalB_i into dbg_rdata_o. dbg_rvalid_o pulses the following cycle, so read latency is gnt+1.
  - Reading address 4'hF returns 0.
- Wait counter:
  - Increments each RUN cycle with dbg_req_i=1 and no grant; clears on grant or when req drops.
  - When it reaches STARVE_LIMIT, go to FORCE.
- FORCE (one cycle):
  - stall_o=1. Pipeline writes and port B are suppressed (rf_dstM_o=rf_dstE_o=4'hF).
  - The debug access is granted on the E port (write) or B port (read).
  - Return to RUN. The held W stage rewrites on the next cycle.
- Grants: at most one per cycle. Back-to-back grants are allowed. After a grant, dbg_req_i must drop or present a new request.
- dbg_rdata_o holds its last value until the next read completes.

Decomposition:
- Shared define file (existing): REG_ADDR_BUS, DATA_BUS, NREG, RNONE=4'hF, DATA_ZERO, RST_EN.
- Add state encodings RFC_INIT/RFC_RUN/RFC_FORCE to the same define file.
- One natural sub-module: regfile_ctrl_portsel (combinational free-port and address-conflict selection). The FSM and counters stay in the top module.

Test Plan:
- Reset release, then 15 cycles: rf_dstE_o steps 0..14 with valE=0, stall_o=busy_o=1; cycle 16 has stall_o=0 and pass-through active.
- RUN, W_dstE=F, W_dstM=3, debug write addr 5 data 0xDEAD: gnt same cycle, rf_dstE_o=5, rf_valE_o=0xDEAD, rf_dstM_o=3.
- RUN, debug write addr 3 while W_dstE=F, W_dstM=3 held: no grant; after 4 cycles, FORCE with stall_o=1, rf_dstM_o=F, rf_dstE_o=3.
- RUN, d_srcB=F, debug read addr 7 with reg7=0x1234: gnt, then next cycle dbg_rvalid_o=1, dbg_rdata_o=0x1234.
- Both ports busy for STARVE_LIMIT cycles with a read pending and d_srcB≠F: exactly one FORCE stall cycle, then rvalid.
- rst asserted mid-wait and mid-INIT: gnt never pulses, INIT restarts at address 0.
